// File: rtl/adc_sample_sequencer.sv
// Round-robin sequencer for an 8-channel 12-bit SPI ADC (AD7928-class, 16-bit frames).
// Emits each conversion result with its channel on a valid/ready stream, with sticky overrun.
module adc_sample_sequencer #(
  parameter int unsigned SCLK_DIV   = 4,
  parameter int unsigned CS_GAP     = 2,
  parameter bit          RANGE_BIT  = 1'b1,
  parameter bit          CODING_BIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  chan_mask,
  input  logic [15:0] sample_period,
  output logic        adc_cs,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic [11:0] smp_data,
  output logic [2:0]  smp_chan,
  output logic        overrun,
  input  logic        overrun_clr,
  output logic        busy
);

  localparam logic [15:0] MIN_FRAME = 16'(1 + 32 * SCLK_DIV + CS_GAP);
  localparam logic [15:0] DIV_LAST  = 16'(SCLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);

  typedef enum logic [2:0] {StIdle, StStart, StShift, StGap, StWait} state_t;

  state_t      r_state;
  logic [2:0]  r_ptr;
  logic        r_first;
  logic [14:0] r_tx;
  logic [14:0] r_rx;
  logic [15:0] r_div;
  logic [3:0]  r_bit;
  logic [15:0] r_gap;
  logic [15:0] r_per;
  logic        r_cs;
  logic        r_sclk;
  logic        r_din;
  logic        r_valid;
  logic [11:0] r_data;
  logic [2:0]  r_chan;
  logic        r_overrun;

  logic [2:0]  w_idx;
  logic [2:0]  w_next_ch;
  logic [14:0] w_ctrl_word;
  logic [15:0] w_period_eff;
  logic        w_run;
  logic        w_arrive;
  logic        w_drop;

  // Lowest-offset enabled channel after the pointer wins; offset 8 wraps back to the pointer.
  always_comb begin
    w_next_ch = r_ptr;
    w_idx     = r_ptr;
    for (int i = 8; i >= 1; i--) begin
      w_idx = r_ptr + 3'(i);
      if (chan_mask[w_idx]) begin
        w_next_ch = w_idx;
      end
    end
  end

  // Bits 14:0 of the control word; the WRITE bit (15) is always 1 and driven directly.
  assign w_ctrl_word  = {1'b0, 1'b0, w_next_ch, 2'b11, 1'b0, 1'b0, RANGE_BIT, CODING_BIT, 4'b0000};
  assign w_period_eff = (sample_period < MIN_FRAME) ? MIN_FRAME : sample_period;
  assign w_run        = enable && (chan_mask != 8'h00);
  assign w_arrive     = (r_state == StGap) && (r_gap == 16'd0) && !r_first;
  assign w_drop       = w_arrive && r_valid && !smp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_ptr     <= 3'd7;
      r_first   <= 1'b1;
      r_tx      <= '0;
      r_rx      <= '0;
      r_div     <= '0;
      r_bit     <= '0;
      r_gap     <= '0;
      r_per     <= '0;
      r_cs      <= 1'b1;
      r_sclk    <= 1'b1;
      r_din     <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_chan    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (r_per != 16'd0) begin
        r_per <= r_per - 16'd1;
      end

      if (r_valid && smp_ready) begin
        r_valid <= 1'b0;
      end
      if (w_arrive && (!r_valid || smp_ready)) begin
        r_valid <= 1'b1;
        r_data  <= r_rx[11:0];
        r_chan  <= r_rx[14:12];
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          r_first <= 1'b1;
          if (w_run) begin
            r_state <= StStart;
            r_cs    <= 1'b0;
            r_din   <= 1'b1;
          end
        end
        StStart: begin
          r_ptr   <= w_next_ch;
          r_tx    <= w_ctrl_word;
          r_per   <= w_period_eff - 16'd1;
          r_sclk  <= 1'b0;
          r_div   <= '0;
          r_bit   <= '0;
          r_state <= StShift;
        end
        StShift: begin
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              r_rx   <= {r_rx[13:0], adc_dout};
            end else if (r_bit == 4'd15) begin
              r_cs    <= 1'b1;
              r_din   <= 1'b0;
              r_gap   <= '0;
              r_state <= StGap;
            end else begin
              r_sclk <= 1'b0;
              r_din  <= r_tx[14];
              r_tx   <= {r_tx[13:0], 1'b0};
              r_bit  <= r_bit + 4'd1;
            end
          end else begin
            r_div <= r_div + 16'd1;
          end
        end
        StGap: begin
          if (r_gap == 16'd0) begin
            r_first <= 1'b0;
          end
          if (r_gap == GAP_LAST) begin
            if (!w_run) begin
              r_state <= StIdle;
            end else if (r_per <= 16'd1) begin
              r_state <= StStart;
              r_cs    <= 1'b0;
              r_din   <= 1'b1;
            end else begin
              r_state <= StWait;
            end
          end else begin
            r_gap <= r_gap + 16'd1;
          end
        end
        StWait: begin
          if (r_per <= 16'd1) begin
            r_state <= StStart;
            r_cs    <= 1'b0;
            r_din   <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign adc_cs    = r_cs;
  assign adc_sclk  = r_sclk;
  assign adc_din   = r_din;
  assign smp_valid = r_valid;
  assign smp_data  = r_data;
  assign smp_chan  = r_chan;
  assign overrun   = r_overrun;
  assign busy      = (r_state == StStart) || (r_state == StShift) || (r_state == StGap);

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer: SPI ADC model with address echo, frame timing,
// channel rotation, stream handshake, overrun and asynchronous reset.
module tb_adc_sample_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  chan_mask;
  logic [15:0] sample_period;
  logic        adc_cs;
  logic        adc_sclk;
  logic        adc_din;
  logic        adc_dout = 1'b0;
  logic        smp_valid;
  logic        smp_ready;
  logic [11:0] smp_data;
  logic [2:0]  smp_chan;
  logic        overrun;
  logic        overrun_clr;
  logic        busy;

  adc_sample_sequencer #(
    .SCLK_DIV  (4),
    .CS_GAP    (2),
    .RANGE_BIT (1'b1),
    .CODING_BIT(1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .chan_mask    (chan_mask),
    .sample_period(sample_period),
    .adc_cs       (adc_cs),
    .adc_sclk     (adc_sclk),
    .adc_din      (adc_din),
    .adc_dout     (adc_dout),
    .smp_valid    (smp_valid),
    .smp_ready    (smp_ready),
    .smp_data     (smp_data),
    .smp_chan     (smp_chan),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: returns {0, previous address, frame tag, previous address} or a fixed word.
  logic [15:0] m_word = 16'h0000;
  logic [15:0] m_cw   = 16'h0000;
  logic [2:0]  m_prev_addr = 3'd0;
  int          m_fall = 0;
  int          m_rise = 0;
  int          m_frame = 0;
  int          last_rises = 0;
  bit          fixed_en = 1'b0;
  logic [15:0] fixed_word = 16'h0000;
  logic [15:0] sent_q[$];
  logic [15:0] cw_q[$];

  always @(negedge adc_cs) begin
    m_frame++;
    m_word = fixed_en ? fixed_word : {1'b0, m_prev_addr, 9'(m_frame), m_prev_addr};
    sent_q.push_back(m_word);
    m_fall = 0;
  end

  always @(negedge adc_sclk) begin
    if (adc_cs === 1'b0 && m_fall < 16) begin
      adc_dout = m_word[15-m_fall];
      m_fall++;
    end
  end

  always @(posedge adc_sclk) begin
    if (adc_cs === 1'b0) begin
      m_cw = {m_cw[14:0], adc_din};
      m_rise++;
    end
  end

  always @(posedge adc_cs) begin
    cw_q.push_back(m_cw);
    last_rises  = m_rise;
    m_rise      = 0;
    m_prev_addr = m_cw[12:10];
  end

  // Pin/stream monitor, sampled mid-cycle.
  logic prev_cs = 1'b1;
  logic prev_valid = 1'b0;
  int   low_cnt = 0;
  int   last_low = 0;
  int   frame_done = 0;
  int   gap_t = 0;
  int   vgap_diff = 0;
  int   start_q[$];
  int   vrise_q[$];
  logic [2:0]  acc_chan_q[$];
  logic [11:0] acc_data_q[$];

  always @(negedge clk) begin
    if (prev_cs && !adc_cs) begin
      start_q.push_back(cyc);
      low_cnt = 0;
    end
    if (!adc_cs) low_cnt++;
    if (!prev_cs && adc_cs) begin
      last_low = low_cnt;
      frame_done++;
      gap_t = cyc;
    end
    if (smp_valid && !prev_valid) begin
      vrise_q.push_back(cyc);
      vgap_diff = cyc - gap_t;
    end
    if (smp_valid && smp_ready) begin
      acc_chan_q.push_back(smp_chan);
      acc_data_q.push_back(smp_data);
    end
    prev_cs    = adc_cs;
    prev_valid = smp_valid;
  end

  int b_fd, b_start, b_vr, b_acc, b_sent, b_cw;
  logic [15:0] tmp16;
  logic [2:0]  exp_wr [5] = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5};
  logic [2:0]  exp_dl [4] = '{3'd2, 3'd5, 3'd7, 3'd2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic mark();
    b_fd    = frame_done;
    b_start = start_q.size();
    b_vr    = vrise_q.size();
    b_acc   = acc_chan_q.size();
    b_sent  = sent_q.size();
    b_cw    = cw_q.size();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (frame_done < b_fd + n && t < budget) begin
      step();
      t++;
    end
    if (frame_done < b_fd + n) chk("frame_timeout", frame_done - b_fd, n);
  endtask

  task automatic go_idle();
    enable = 1'b0;
    repeat (1200) step();
    chk("idle_busy", busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cs"}, adc_cs, 1);
    chk({tag, "_sclk"}, adc_sclk, 1);
    chk({tag, "_din"}, adc_din, 0);
    chk({tag, "_valid"}, smp_valid, 0);
    chk({tag, "_data"}, smp_data, 0);
    chk({tag, "_chan"}, smp_chan, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; chan_mask = 8'h01; sample_period = 16'd0;
    smp_ready = 1'b1; overrun_clr = 1'b0;
    step(); step();
    chk_reset_vals("rst");

    // Back-to-back frames on channel 0.
    mark();
    enable = 1'b1;
    reset  = 1'b0;
    wait_frames(3, 600);
    repeat (3) step();
    chk("t1_rises", last_rises, 16);
    chk("t1_cs_low", last_low, 129);
    chk("t1_start_to_start", start_q[b_start+1] - start_q[b_start], 131);
    chk("t1_ctrl_word", cw_q[b_cw], 16'h8330);
    chk("t1_delivered", acc_chan_q.size() - b_acc, 2);
    chk("t1_chan0", acc_chan_q[b_acc], 0);
    chk("t1_chan1", acc_chan_q[b_acc+1], 0);
    tmp16 = sent_q[b_sent+1];
    chk("t1_data0", acc_data_q[b_acc], tmp16[11:0]);
    go_idle();

    // Rotation over 2,5,7.
    mark();
    chan_mask = 8'b1010_0100;
    enable    = 1'b1;
    wait_frames(5, 900);
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      tmp16 = cw_q[b_cw+i];
      chk($sformatf("t2_wr_addr%0d", i), tmp16[12:10], exp_wr[i]);
    end
    chk("t2_delivered", acc_chan_q.size() - b_acc, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_dl_chan%0d", i), acc_chan_q[b_acc+i], exp_dl[i]);
    end
    go_idle();

    // Programmed period of 1000 cycles.
    mark();
    chan_mask     = 8'h01;
    sample_period = 16'd1000;
    enable        = 1'b1;
    wait_frames(3, 3500);
    repeat (3) step();
    chk("t3_period0", start_q[b_start+1] - start_q[b_start], 1000);
    chk("t3_period1", start_q[b_start+2] - start_q[b_start+1], 1000);
    chk("t3_valid_pulses", vrise_q.size() - b_vr, 2);
    chk("t3_valid_spacing", vrise_q[b_vr+1] - vrise_q[b_vr], 1000);
    go_idle();

    // Fixed ADC word 16'h3ABC.
    mark();
    sample_period = 16'd0;
    fixed_word    = 16'h3ABC;
    fixed_en      = 1'b1;
    enable        = 1'b1;
    wait_frames(2, 600);
    repeat (3) step();
    chk("t4_chan", acc_chan_q[b_acc], 3);
    chk("t4_data", acc_data_q[b_acc], 12'hABC);
    chk("t4_valid_lat", vgap_diff, 1);
    go_idle();
    fixed_en = 1'b0;

    // Stalled consumer and overrun.
    mark();
    chan_mask = 8'h08;
    smp_ready = 1'b0;
    enable    = 1'b1;
    wait_frames(3, 800);
    repeat (2) step();
    tmp16 = sent_q[b_sent+1];
    chk("t5_held_valid", smp_valid, 1);
    chk("t5_held_data", smp_data, tmp16[11:0]);
    chk("t5_held_chan", smp_chan, 3);
    chk("t5_overrun_set", overrun, 1);
    wait_frames(4, 300);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("t5_set_wins", overrun, 1);
    chk("t5_still_held", smp_data, tmp16[11:0]);
    wait_frames(5, 300);
    smp_ready = 1'b1;
    step();
    tmp16 = sent_q[b_sent+4];
    chk("t5_replace_valid", smp_valid, 1);
    chk("t5_replace_data", smp_data, tmp16[11:0]);
    chk("t5_no_new_overrun", overrun, 1);
    smp_ready = 1'b0;
    step();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("t5_cleared", overrun, 0);
    chk("t5_valid_kept", smp_valid, 1);
    wait_frames(6, 300);
    repeat (2) step();
    chk("t5_overrun_again", overrun, 1);
    chk("t5_data_kept", smp_data, tmp16[11:0]);

    // Asynchronous reset in the middle of a shift.
    repeat (25) step();
    chk("t6_mid_frame", adc_cs, 0);
    smp_ready = 1'b1;
    reset     = 1'b1;
    #1;
    chk_reset_vals("t6_async");
    step(); step();
    mark();
    reset = 1'b0;
    wait_frames(1, 300);
    repeat (4) step();
    chk("t6_dummy_no_valid", vrise_q.size() - b_vr, 0);
    wait_frames(2, 300);
    repeat (3) step();
    chk("t6_second_valid", vrise_q.size() - b_vr, 1);
    chk("t6_second_chan", acc_chan_q[b_acc], 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
